// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 convolution window generator
// Rows land in a 4-slot ring of line memories; windows are read from the oldest three rows.
module conv_window_gen #(
  parameter int DATA_RES     = 8,
  parameter int KERNEL_WIDTH = 3,
  parameter int LINE_WIDTH   = 28,
  parameter int NUM_LINES    = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_RES-1:0]   pixel_i,
  input  logic                  pixel_valid_i,
  output logic                  pixel_ready_o,
  output logic [9*DATA_RES-1:0] window_o,
  output logic                  window_valid_o,
  input  logic                  window_ready_i,
  output logic                  frame_done_o
);
  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(NUM_LINES + 1);
  localparam logic [CW-1:0] WR_COL_LAST  = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] RD_COL_LAST  = CW'(LINE_WIDTH - KERNEL_WIDTH);
  localparam logic [RW-1:0] ROWS_PER_IMG = RW'(NUM_LINES);
  localparam logic [RW-1:0] OUT_ROW_LAST = RW'(NUM_LINES - KERNEL_WIDTH);

  typedef enum logic [1:0] {FILL, OUT, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_RES-1:0] line_mem [4][LINE_WIDTH];
  logic [1:0]          wr_slot, rd_slot;
  logic [CW-1:0]       wr_col, rd_col;
  logic [RW-1:0]       in_row, out_row;
  logic [2:0]          lines_filled, lines_nxt;
  logic                pix_acc, line_done, win_hs, row_rel;

  assign pixel_ready_o  = (lines_filled < 3'd4) && (in_row < ROWS_PER_IMG) && (state != DONE) && !rst_i;
  assign window_valid_o = (state == OUT) && !rst_i;
  assign frame_done_o   = (state == DONE) && !rst_i;

  assign pix_acc   = pixel_valid_i && pixel_ready_o;
  assign line_done = pix_acc && (wr_col == WR_COL_LAST);
  assign win_hs    = window_valid_o && window_ready_i;
  assign row_rel   = win_hs && (rd_col == RD_COL_LAST);

  // A row completing and a row retiring in the same cycle cancel out.
  always_comb begin
    lines_nxt = lines_filled;
    if (line_done && !row_rel)
      lines_nxt = lines_filled + 3'd1;
    else if (!line_done && row_rel)
      lines_nxt = lines_filled - 3'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (lines_nxt >= 3'd3) state_nxt = OUT;
      OUT: begin
        if (row_rel) begin
          if (out_row == OUT_ROW_LAST)
            state_nxt = DONE;
          else if (lines_nxt < 3'd3)
            state_nxt = FILL;
        end
      end
      DONE:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || state == DONE) begin
      state        <= (rst_i) ? FILL : state_nxt;
      wr_slot      <= '0;
      rd_slot      <= '0;
      wr_col       <= '0;
      rd_col       <= '0;
      in_row       <= '0;
      out_row      <= '0;
      lines_filled <= '0;
    end else begin
      state        <= state_nxt;
      lines_filled <= lines_nxt;
      if (pix_acc) begin
        if (line_done) begin
          wr_col  <= '0;
          wr_slot <= wr_slot + 2'd1;
          in_row  <= in_row + RW'(1);
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
      if (win_hs) begin
        if (row_rel) begin
          rd_col  <= '0;
          rd_slot <= rd_slot + 2'd1;
          out_row <= out_row + RW'(1);
        end else begin
          rd_col <= rd_col + CW'(1);
        end
      end
    end
  end

  // Line memory keeps its contents across reset; the counters alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (pix_acc)
      line_mem[wr_slot][wr_col] <= pixel_i;
  end

  always_comb begin
    window_o = '0;
    if (!rst_i) begin
      for (int r = 0; r < KERNEL_WIDTH; r++) begin
        for (int c = 0; c < KERNEL_WIDTH; c++) begin
          window_o[(KERNEL_WIDTH*KERNEL_WIDTH-1-(r*KERNEL_WIDTH+c))*DATA_RES +: DATA_RES] =
            line_mem[rd_slot + 2'(r)][rd_col + CW'(c)];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen
// Driver pushes expected windows per frame; a negedge monitor pops and checks handshakes and flow control.
module tb_conv_window_gen;
  localparam int LW  = 28;
  localparam int NL  = 28;
  localparam int WPF = (LW - 2) * (NL - 2);
  localparam int PPF = LW * NL;

  localparam logic [71:0] FIRST_RAMP0 = {8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
  localparam logic [71:0] LAST_RAMP0  = {8'd213, 8'd214, 8'd215, 8'd241, 8'd242, 8'd243, 8'd13, 8'd14, 8'd15};
  localparam logic [71:0] ROW1_RAMP0  = {8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58, 8'd84, 8'd85, 8'd86};
  localparam logic [71:0] FIRST_RAMP1 = {8'd1, 8'd2, 8'd3, 8'd29, 8'd30, 8'd31, 8'd57, 8'd58, 8'd59};
  localparam logic [71:0] FIRST_RAMP5 = {8'd5, 8'd6, 8'd7, 8'd33, 8'd34, 8'd35, 8'd61, 8'd62, 8'd63};

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  pixel_i;
  logic        pixel_valid_i;
  logic        pixel_ready_o;
  logic [71:0] window_o;
  logic        window_valid_o;
  logic        window_ready_i;
  logic        frame_done_o;

  conv_window_gen dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pixel_i        (pixel_i),
    .pixel_valid_i  (pixel_valid_i),
    .pixel_ready_o  (pixel_ready_o),
    .window_o       (window_o),
    .window_valid_o (window_valid_o),
    .window_ready_i (window_ready_i),
    .frame_done_o   (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int          tests = 0;
  int          fails = 0;
  int          px_cnt = 0;
  int          win_cnt = 0;
  int          done_cnt = 0;
  int          rmode = 0;
  int          stall_n = 0;
  bit          done_exp = 0;
  bit          stalled = 0;
  bit          seen_valid = 0;
  bit          saw_full = 0;
  bit          aborted;
  logic [71:0] held, first_win, last_win, row1_win;
  logic [71:0] exp_q [$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input int off);
    return 8'((r * LW + c + off) % 256);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c, input int off);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (i * 3 + j)) * 8 +: 8] = pix(r + i, c + j, off);
    return w;
  endfunction

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic feed(input int off, input bit gap, input int abort_at, output bit ab);
    bit acc;
    int budget;
    ab = 0;
    for (int r = 0; r < NL - 2; r++)
      for (int c = 0; c < LW - 2; c++)
        exp_q.push_back(exp_win(r, c, off));
    for (int p = 0; p < PPF; p++) begin
      if (gap) begin
        pixel_valid_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
      end
      pixel_i       = pix(p / LW, p % LW, off);
      pixel_valid_i = 1'b1;
      acc    = 0;
      budget = 0;
      while (!acc) begin
        @(negedge clk_i);
        acc = pixel_ready_o;
        @(posedge clk_i); #1;
        if (abort_at > 0 && win_cnt >= abort_at) begin
          pixel_valid_i = 1'b0;
          ab = 1;
          return;
        end
        budget++;
        if (budget > 3000) begin
          tests++;
          fails++;
          $display("FAIL feed_timeout: pixel %0d not accepted, expected accept within 3000 cycles", p);
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $fatal(1, "stalled input");
        end
      end
    end
    pixel_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int b;
    b = 0;
    while (done_cnt < n && b < 5000) begin
      @(posedge clk_i); #1;
      b++;
    end
    chk("frame_done_count", done_cnt, n);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    case (rmode)
      0: window_ready_i = 1'b1;
      1: window_ready_i = 1'($urandom_range(0, 1));
      default: begin
        if (window_valid_o && stall_n < 2) begin
          window_ready_i = 1'b0;
          stall_n++;
        end else begin
          window_ready_i = 1'b1;
        end
      end
    endcase
  end

  // Line occupancy is derived from accepted pixels and retired rows, independent of the DUT counters.
  initial forever begin
    int lf;
    bit hs;
    @(negedge clk_i);
    if (rst_i) begin
      chk("rst_pixel_ready", pixel_ready_o, 0);
      chk("rst_window_valid", window_valid_o, 0);
      chk("rst_frame_done", frame_done_o, 0);
      chk("rst_window", window_o, 0);
      px_cnt = 0; win_cnt = 0; done_exp = 0; stalled = 0; seen_valid = 0;
    end else begin
      lf = px_cnt / LW - win_cnt / (LW - 2);
      chk("window_valid", window_valid_o, (lf >= 3 && win_cnt < WPF));
      chk("pixel_ready", pixel_ready_o, (!done_exp && px_cnt < PPF && lf < 4));
      chk("frame_done", frame_done_o, done_exp);
      if (stalled) chk("stall_hold", window_o, held);
      if (window_valid_o && !seen_valid) begin
        chk("first_valid_pixels", px_cnt, 84);
        seen_valid = 1;
      end
      if (rmode == 1 && !pixel_ready_o && !done_exp && px_cnt < PPF) saw_full = 1;
      hs = window_valid_o && window_ready_i;
      if (hs) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL window: got %h, expected no window", window_o);
        end else begin
          chk("window", window_o, exp_q.pop_front());
        end
        if (win_cnt == 0) first_win = window_o;
        if (win_cnt == 26) row1_win = window_o;
        if (win_cnt == WPF - 1) last_win = window_o;
        if (rmode == 2 && win_cnt == 25) begin
          chk("coincide_accept", pixel_valid_i && pixel_ready_o, 1);
          chk("coincide_px", px_cnt, 111);
        end
        win_cnt++;
      end
      stalled = window_valid_o && !window_ready_i;
      held    = window_o;
      if (pixel_valid_i && pixel_ready_o) px_cnt++;
      if (frame_done_o) done_cnt++;
      if (done_exp) begin
        px_cnt = 0; win_cnt = 0; seen_valid = 0; done_exp = 0;
      end else if (hs && win_cnt == WPF) begin
        done_exp = 1;
      end
    end
  end

  initial begin
    rst_i = 1'b1; pixel_valid_i = 1'b0; pixel_i = '0; window_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    rmode = 0;
    feed(0, 0, 0, aborted);
    wait_done(1);
    chk("first_window_ramp0", first_win, FIRST_RAMP0);
    chk("last_window_ramp0", last_win, LAST_RAMP0);

    rmode = 1; saw_full = 0;
    feed(0, 0, 0, aborted);
    wait_done(2);
    chk("backpressure_full", saw_full, 1);

    rmode = 0;
    feed(0, 1, 0, aborted);
    wait_done(3);
    chk("gap_first_window", first_win, FIRST_RAMP0);

    stall_n = 0; rmode = 2;
    feed(0, 0, 0, aborted);
    wait_done(4);
    chk("row1_first_window", row1_win, ROW1_RAMP0);

    rmode = 0;
    feed(0, 0, 400, aborted);
    chk("abort_reached", aborted, 1);
    rst_i = 1'b1;
    exp_q.delete();
    repeat (3) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
    chk("no_abort_done", done_cnt, 4);
    feed(1, 0, 0, aborted);
    wait_done(5);
    chk("first_window_ramp1", first_win, FIRST_RAMP1);

    feed(0, 0, 0, aborted);
    feed(5, 0, 0, aborted);
    wait_done(7);
    chk("first_window_ramp5", first_win, FIRST_RAMP5);

    repeat (3) @(posedge clk_i);
    finish_run();
  end

endmodule
